// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types and line levels
package uart_pkg;
  localparam int DATA_BITS = 8;
  localparam logic IDLE_LEVEL = 1'b1;
  localparam logic START_LEVEL = 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_POP,
    ST_WAIT,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_t;

  function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
    return ^d;
  endfunction
endpackage

// File: rtl/uart_baud_tick.sv
// rtl/uart_baud_tick.sv - bit-period counter with clear, ticks on the last cycle of each bit
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic en,
  output logic tick
);
  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q;

  assign tick = en && (cnt_q == LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= tick ? '0 : cnt_q + CNT_W'(1);
    end
  end
endmodule

// File: rtl/uart_tx_drain.sv
// rtl/uart_tx_drain.sv - 8N1 UART transmitter that pops bytes from an upstream FIFO
// Define UART_TX_PARITY_EN to append an even-parity bit before the stop bit.
module uart_tx_drain
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_data,
  output logic       fifo_pop,
  output logic       tx,
  output logic       busy
);
  localparam int BIT_W = $clog2(DATA_BITS);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_BITS - 1);

  tx_state_t state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic tx_d, pop_d, busy_d;
  logic baud_clear, tick;
`ifdef UART_TX_PARITY_EN
  logic parity_q, parity_d;
`endif

  // The counter is held at zero outside the bit-timed states so START always gets a full period.
  assign baud_clear = (state_q == ST_IDLE) || (state_q == ST_POP) || (state_q == ST_WAIT);

  uart_baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk  (clk),
    .reset(reset),
    .clear(baud_clear),
    .en   (!baud_clear),
    .tick (tick)
  );

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    tx_d      = tx;
    pop_d     = 1'b0;
    busy_d    = busy;
`ifdef UART_TX_PARITY_EN
    parity_d  = parity_q;
`endif
    case (state_q)
      ST_IDLE: begin
        tx_d = IDLE_LEVEL;
        if (!fifo_empty) begin
          pop_d   = 1'b1;
          busy_d  = 1'b1;
          state_d = ST_POP;
        end
      end
      ST_POP: state_d = ST_WAIT;
      ST_WAIT: begin
        shift_d = fifo_data;
        tx_d    = START_LEVEL;
        state_d = ST_START;
`ifdef UART_TX_PARITY_EN
        parity_d = even_parity(fifo_data);
`endif
      end
      ST_START: begin
        if (tick) begin
          tx_d      = shift_q[0];
          shift_d   = shift_q >> 1;
          bit_cnt_d = '0;
          state_d   = ST_DATA;
        end
      end
      ST_DATA: begin
        if (tick) begin
          if (bit_cnt_q == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
            tx_d    = parity_q;
            state_d = ST_PARITY;
`else
            tx_d    = IDLE_LEVEL;
            state_d = ST_STOP;
`endif
          end else begin
            tx_d      = shift_q[0];
            shift_d   = shift_q >> 1;
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
          end
        end
      end
      ST_PARITY: begin
        if (tick) begin
          tx_d    = IDLE_LEVEL;
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (tick) begin
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        tx_d    = IDLE_LEVEL;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      tx        <= IDLE_LEVEL;
      fifo_pop  <= 1'b0;
      busy      <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      tx        <= tx_d;
      fifo_pop  <= pop_d;
      busy      <= busy_d;
`ifdef UART_TX_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end
endmodule
